// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 panel scan engine (shift, blank, latch, display per row pair)
// Ports: clk/rst sync active-high; en scan enable; R0..B1 pixel bits for (col,row);
// col/row index to pixel source; HR0..HB1 panel data; HCLK shift clock; HLAT latch;
// HOE_N output enable (low = on); HADDR row-pair address; frame_done one-cycle end-of-frame; busy.
module hub75_scan_driver #(
    parameter int COLS      = 64,
    parameter int ROWS_HALF = 16,
    parameter int CLK_DIV   = 2,
    parameter int LAT_CYC   = 2,
    parameter int ON_CYC    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         R0,
    input  logic                         G0,
    input  logic                         B0,
    input  logic                         R1,
    input  logic                         G1,
    input  logic                         B1,
    output logic [$clog2(COLS)-1:0]      col,
    output logic [$clog2(ROWS_HALF)-1:0] row,
    output logic                         HR0,
    output logic                         HG0,
    output logic                         HB0,
    output logic                         HR1,
    output logic                         HG1,
    output logic                         HB1,
    output logic                         HCLK,
    output logic                         HLAT,
    output logic                         HOE_N,
    output logic [$clog2(ROWS_HALF)-1:0] HADDR,
    output logic                         frame_done,
    output logic                         busy
);
    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS_HALF);
    localparam int PW   = $clog2(2 * CLK_DIV);
    localparam int CMAX = (LAT_CYC > ON_CYC) ? LAT_CYC : ON_CYC;
    localparam int NW   = $clog2(CMAX + 1);
    localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(ROWS_HALF - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV - 1);
    localparam logic [NW-1:0] LAT_LAST = NW'(LAT_CYC - 1);
    localparam logic [NW-1:0] ON_LAST  = NW'(ON_CYC - 1);
    state_t          state;
    logic [PW-1:0]   ph;
    logic [NW-1:0]   cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ph         <= '0;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            HADDR      <= '0;
            {HR0, HG0, HB0, HR1, HG1, HB1} <= '0;
            HCLK       <= 1'b0;
            HLAT       <= 1'b0;
            HOE_N      <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                    col   <= '0;
                    ph    <= '0;
                end
                SHIFT: begin
                    ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
                    // col changed on entry to ph=0, so the pixel source has had a full cycle
                    if (ph == '0) {HR0, HG0, HB0, HR1, HG1, HB1} <= {R0, G0, B0, R1, G1, B1};
                    if (ph == PH_RISE) HCLK <= 1'b1;
                    if (ph == PH_LAST) begin
                        HCLK <= 1'b0;
                        if (col == COL_LAST) state <= BLANK;
                        else col <= col + 1'b1;
                    end
                end
                BLANK: begin
                    state <= LATCH;
                    HLAT  <= 1'b1;
                    HADDR <= row;
                    cnt   <= '0;
                end
                LATCH: if (cnt == LAT_LAST) begin
                    state <= DISPLAY;
                    HLAT  <= 1'b0;
                    HOE_N <= 1'b0;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
                DISPLAY: if (cnt == ON_LAST) begin
                    HOE_N      <= 1'b1;
                    col        <= '0;
                    ph         <= '0;
                    row        <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    frame_done <= (row == ROW_LAST);
                    state      <= en ? SHIFT : IDLE;
                    busy       <= en;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed table-driven bench for hub75_scan_driver (default parameters)
module tb_hub75_scan_driver;
    logic       clk = 1'b0;
    logic       rst, en;
    logic       R0, G0, B0, R1, G1, B1;
    logic [5:0] col;
    logic [3:0] row, HADDR;
    logic       HR0, HG0, HB0, HR1, HG1, HB1, HCLK, HLAT, HOE_N, frame_done, busy;
    int         total = 0, passed = 0;

    hub75_scan_driver dut (
        .clk(clk), .rst(rst), .en(en),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .col(col), .row(row),
        .HR0(HR0), .HG0(HG0), .HB0(HB0), .HR1(HR1), .HG1(HG1), .HB1(HB1),
        .HCLK(HCLK), .HLAT(HLAT), .HOE_N(HOE_N), .HADDR(HADDR),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // combinational pixel source
    always_comb begin
        R0 = col[0];
        G0 = row[0];
        B0 = col[1];
        R1 = ~col[1];
        G1 = row[1];
        B1 = ~col[0];
    end

    typedef struct {
        int         cyc;
        logic [5:0] col;
        logic [3:0] row;
        logic       hclk, hlat, hoe_n, hr0, hb1;
        logic [3:0] haddr;
    } vec_t;

    vec_t tv[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        int ti, rises, chg_err, bit_err, hoe_low, hlat_hi, overlap, busy_err;
        int hl1, hl2, fd_n, fd1, fd2, fd_row_err, n;
        logic ph_clk, ph_lat, found;
        logic [5:0] prev_d;
        // cyc (cycles after SHIFT entry), col, row, hclk, hlat, hoe_n, hr0, hb1, haddr
        tv[0]  = '{0,   6'd0,  4'd0, 0, 0, 1, 0, 0, 4'd0};
        tv[1]  = '{1,   6'd0,  4'd0, 0, 0, 1, 0, 1, 4'd0};
        tv[2]  = '{2,   6'd0,  4'd0, 1, 0, 1, 0, 1, 4'd0};
        tv[3]  = '{3,   6'd0,  4'd0, 1, 0, 1, 0, 1, 4'd0};
        tv[4]  = '{4,   6'd1,  4'd0, 0, 0, 1, 0, 1, 4'd0};
        tv[5]  = '{5,   6'd1,  4'd0, 0, 0, 1, 1, 0, 4'd0};
        tv[6]  = '{6,   6'd1,  4'd0, 1, 0, 1, 1, 0, 4'd0};
        tv[7]  = '{255, 6'd63, 4'd0, 1, 0, 1, 1, 0, 4'd0};
        tv[8]  = '{256, 6'd63, 4'd0, 0, 0, 1, 1, 0, 4'd0};
        tv[9]  = '{257, 6'd63, 4'd0, 0, 1, 1, 1, 0, 4'd0};
        tv[10] = '{258, 6'd63, 4'd0, 0, 1, 1, 1, 0, 4'd0};
        tv[11] = '{259, 6'd63, 4'd0, 0, 0, 0, 1, 0, 4'd0};
        tv[12] = '{322, 6'd63, 4'd0, 0, 0, 0, 1, 0, 4'd0};
        tv[13] = '{323, 6'd0,  4'd1, 0, 0, 1, 1, 0, 4'd0};
        tv[14] = '{324, 6'd0,  4'd1, 0, 0, 1, 0, 1, 4'd0};
        tv[15] = '{580, 6'd63, 4'd1, 0, 1, 1, 1, 0, 4'd1};
        tv[16] = '{581, 6'd63, 4'd1, 0, 1, 1, 1, 0, 4'd1};
        tv[17] = '{582, 6'd63, 4'd1, 0, 0, 0, 1, 0, 4'd1};

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_state", {col, row, HADDR, HR0, HG0, HB0, HR1, HG1, HB1, HCLK, HLAT, HOE_N, frame_done, busy},
            {6'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        en = 1'b1;
        step();
        chk("busy_after_en", busy, 1'b1);

        ti = 0; rises = 0; chg_err = 0; bit_err = 0; hoe_low = 0; hlat_hi = 0; overlap = 0; busy_err = 0;
        hl1 = -1; hl2 = -1; fd_n = 0; fd1 = -1; fd2 = -1; fd_row_err = 0;
        ph_clk = 1'b0; ph_lat = 1'b0; prev_d = '0;
        for (int k = 0; k <= 10340; k++) begin
            if (ti < 18 && tv[ti].cyc == k) begin
                chk($sformatf("vec_cyc%0d", k), {col, row, HCLK, HLAT, HOE_N, HR0, HB1, HADDR},
                    {tv[ti].col, tv[ti].row, tv[ti].hclk, tv[ti].hlat, tv[ti].hoe_n, tv[ti].hr0, tv[ti].hb1, tv[ti].haddr});
                ti++;
            end
            if (HCLK && !ph_clk) begin
                if ({HR0, HG0, HB0, HR1, HG1, HB1} != prev_d) chg_err++;
                if (hl1 < 0) begin
                    if (HR0 != rises[0] || HB1 != ~rises[0]) bit_err++;
                    rises++;
                end
            end
            if (HLAT && !ph_lat) begin
                if (hl1 < 0) hl1 = k;
                else if (hl2 < 0) hl2 = k;
            end
            if (k < 323 && !HOE_N) hoe_low++;
            if (k < 323 && HLAT) hlat_hi++;
            if (HLAT && !HOE_N) overlap++;
            if (!busy) busy_err++;
            if (frame_done) begin
                if (fd_n == 0) fd1 = k;
                else if (fd_n == 1) fd2 = k;
                fd_n++;
                if (row != 4'd0) fd_row_err++;
            end
            ph_clk = HCLK;
            ph_lat = HLAT;
            prev_d = {HR0, HG0, HB0, HR1, HG1, HB1};
            step();
        end
        chk("table_applied", ti, 18);
        chk("hclk_rises_before_lat", rises, 64);
        chk("data_stable_at_rise", chg_err, 0);
        chk("captured_bits_alternate", bit_err, 0);
        chk("hoe_low_cycles", hoe_low, 64);
        chk("hlat_high_cycles", hlat_hi, 2);
        chk("hlat_hoe_overlap", overlap, 0);
        chk("busy_while_scanning", busy_err, 0);
        chk("row_period", hl2 - hl1, 323);
        chk("frame_done_count", fd_n, 2);
        chk("frame_done_first", fd1, 5168);
        chk("frame_done_period", fd2 - fd1, 5168);
        chk("frame_done_row0", fd_row_err, 0);

        // drop en inside row 5; the row must still complete
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (row == 4'd5) found = 1'b1;
            else step();
        end
        chk("reach_row5", found, 1'b1);
        repeat (10) step();
        en = 1'b0;
        n = 10; hoe_low = 0; found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (!busy) found = 1'b1;
            else begin
                if (!HOE_N) hoe_low++;
                step();
                n++;
            end
        end
        chk("en_drop_idle_reached", found, 1'b1);
        chk("en_drop_row_length", n, 323);
        chk("en_drop_row5_display", hoe_low, 64);
        chk("en_drop_idle_outputs", {row, HOE_N, busy, col}, {4'd6, 1'b1, 1'b0, 6'd0});
        repeat (3) step();
        chk("idle_holds", {busy, HOE_N, HCLK}, {1'b0, 1'b1, 1'b0});
        en = 1'b1;
        step();
        chk("resume_row6", {busy, row, col}, {1'b1, 4'd6, 6'd0});
        repeat (257) step();
        chk("resume_latch_addr", {HLAT, HADDR}, {1'b1, 4'd6});

        // reset during display of row 3
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            if (row == 4'd3 && !HOE_N) found = 1'b1;
            else step();
        end
        chk("reach_row3_display", found, 1'b1);
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("mid_display_reset", {HOE_N, HCLK, HLAT, row, col, HADDR, busy, frame_done},
            {1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 4'd0, 1'b0, 1'b0});
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) step();
        chk("idle_after_reset", {busy, HOE_N}, {1'b0, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
